// File: rtl/segment_chaser_pkg.sv
// Shared definitions for the segment chaser: mode encodings, the default
// figure-8 sequence map and the index-width helper.
package segment_chaser_pkg;

    typedef enum logic [1:0] {
        MODE_LOOP   = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_STEP   = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    // Figure-8 walk over a 7-segment digit: 0,1,6,4,3,2,6,5 (entry 0 in the LSBs).
    localparam logic [23:0] DEFAULT_SEQ_MAP = 24'hB93988;

    // Bits needed to index n items; never below 1 so slices stay legal.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/segment_chaser_if.sv
// Control and status bundle between the I/O wrapper and the chaser core.
interface segment_chaser_if #(
    parameter int NUM_SEG = 7,
    parameter int SEQ_LEN = 8
);
    logic [2:0]                 speed;
    logic [1:0]                 mode;
    logic                       direction;
    logic                       tail_en;
    logic                       invert;
    logic                       step;
    logic [NUM_SEG-1:0]         seg_out;
    logic [$clog2(SEQ_LEN)-1:0] pos_out;
    logic                       wrap;

    modport master (
        output speed, mode, direction, tail_en, invert, step,
        input  seg_out, pos_out, wrap
    );

    modport slave (
        input  speed, mode, direction, tail_en, invert, step,
        output seg_out, pos_out, wrap
    );
endinterface

// File: rtl/fade_pwm_channel.sv
// One segment: brightness register with load/decay and its PWM compare.
module fade_pwm_channel #(
    parameter int FADE_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    input  logic                  tail_en,
    input  logic                  fade_tick,
    input  logic [FADE_WIDTH-1:0] pwm,
    input  logic                  invert,
    output logic                  seg
);
    logic [FADE_WIDTH-1:0] bright;

    // Active segment goes full on; otherwise clear or halve on each fade tick.
    always_ff @(posedge clk) begin
        if (reset)          bright <= '0;
        else if (active)    bright <= '1;
        else if (!tail_en)  bright <= '0;
        else if (fade_tick) bright <= bright >> 1;
    end

    // Registered PWM drive; a full-scale value is lit on all but one pwm phase.
    always_ff @(posedge clk) begin
        if (reset) seg <= 1'b0;
        else       seg <= (bright > pwm) ^ invert;
    end
endmodule

// File: rtl/segment_chaser.sv
// Segment chaser core: input stage, step prescaler, position sequencer and
// fade divider, feeding one fade/PWM channel per segment.
module segment_chaser
    import segment_chaser_pkg::*;
#(
    parameter int NUM_SEG        = 7,
    parameter int SEQ_LEN        = 8,
    parameter logic [SEQ_LEN*idx_width(NUM_SEG)-1:0] SEQ_MAP = DEFAULT_SEQ_MAP,
    parameter int FADE_WIDTH     = 4,
    parameter int PRESCALE_WIDTH = 11,
    parameter int FADE_DIV_WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    segment_chaser_if.slave  bus
);
    localparam int SW = idx_width(NUM_SEG);
    localparam int PW = $clog2(SEQ_LEN);
    localparam logic [PW-1:0] LAST = PW'(SEQ_LEN - 1);

    logic [2:0]                speed_r;
    mode_e                     mode_r, mode_q;
    logic                      direction_r, tail_en_r, invert_r;
    logic                      step_r, step_rr, step_evt;
    logic [PRESCALE_WIDTH-1:0] pcnt, limit;
    logic                      tick;
    logic [FADE_DIV_WIDTH-1:0] fdiv;
    logic                      fade_tick;
    logic [FADE_WIDTH-1:0]     pwm;
    logic [PW-1:0]             pos, pos_nxt, pos_up, pos_dn, loop_pos;
    logic                      bdir, bdir_nxt, dir_b, wrap, wrap_nxt, loop_wrap;
    logic [SW-1:0]             cur_seg;
    logic [NUM_SEG-1:0]        seg;

    // Register every control input once; step gets an extra stage for edge detect,
    // and the detected edge is registered so it acts three cycles after the pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            speed_r     <= '0;
            mode_r      <= MODE_LOOP;
            mode_q      <= MODE_LOOP;
            direction_r <= 1'b0;
            tail_en_r   <= 1'b0;
            invert_r    <= 1'b0;
            step_r      <= 1'b0;
            step_rr     <= 1'b0;
            step_evt    <= 1'b0;
        end else begin
            speed_r     <= bus.speed;
            mode_r      <= mode_e'(bus.mode);
            mode_q      <= mode_r;
            direction_r <= bus.direction;
            tail_en_r   <= bus.tail_en;
            invert_r    <= bus.invert;
            step_r      <= bus.step;
            step_rr     <= step_r;
            step_evt    <= step_r & ~step_rr;
        end
    end

    assign limit     = {speed_r, {(PRESCALE_WIDTH-3){1'b1}}};
    assign tick      = (pcnt >= limit);   // >= so a lowered limit fires at once
    assign fade_tick = (fdiv == '0);

    // Free-running prescaler, fade divider and PWM ramp; they run in all modes.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
            fdiv <= '0;
            pwm  <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            fdiv <= fdiv + 1'b1;
            pwm  <= pwm + 1'b1;
        end
    end

    assign pos_up    = (pos == LAST) ? '0 : pos + 1'b1;
    assign pos_dn    = (pos == '0) ? LAST : pos - 1'b1;
    assign loop_pos  = direction_r ? pos_up : pos_dn;
    assign loop_wrap = direction_r ? (pos == LAST) : (pos == '0);
    // On the first BOUNCE cycle the bounce direction comes from the pin.
    assign dir_b     = (mode_q != MODE_BOUNCE) ? direction_r : bdir;

    // Next position / bounce direction / wrap for the currently selected mode.
    always_comb begin
        pos_nxt  = pos;
        bdir_nxt = bdir;
        wrap_nxt = 1'b0;
        unique case (mode_r)
            MODE_LOOP: if (tick) begin
                pos_nxt  = loop_pos;
                wrap_nxt = loop_wrap;
            end
            MODE_STEP: if (step_evt) begin
                pos_nxt  = loop_pos;
                wrap_nxt = loop_wrap;
            end
            MODE_BOUNCE: begin
                bdir_nxt = dir_b;
                if (tick) begin
                    if (dir_b && pos == LAST) begin
                        pos_nxt  = pos - 1'b1;
                        bdir_nxt = 1'b0;
                        wrap_nxt = 1'b1;
                    end else if (!dir_b && pos == '0) begin
                        pos_nxt  = pos + 1'b1;
                        bdir_nxt = 1'b1;
                        wrap_nxt = 1'b1;
                    end else begin
                        pos_nxt  = dir_b ? pos + 1'b1 : pos - 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Sequencer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos  <= '0;
            bdir <= 1'b1;
            wrap <= 1'b0;
        end else begin
            pos  <= pos_nxt;
            bdir <= bdir_nxt;
            wrap <= wrap_nxt;
        end
    end

    assign cur_seg = SEQ_MAP[pos*SW +: SW];

    for (genvar i = 0; i < NUM_SEG; i++) begin : g_ch
        fade_pwm_channel #(.FADE_WIDTH(FADE_WIDTH)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .active    (cur_seg == SW'(i)),
            .tail_en   (tail_en_r),
            .fade_tick (fade_tick),
            .pwm       (pwm),
            .invert    (invert_r),
            .seg       (seg[i])
        );
    end

    assign bus.seg_out = seg;
    assign bus.pos_out = pos;
    assign bus.wrap    = wrap;
endmodule

// File: tb/tb_segment_chaser.sv
// Directed bench for segment_chaser: a vector table for position/wrap
// behaviour plus sequences for fading, step mode, invert and reset.
module tb_segment_chaser;
    import segment_chaser_pkg::*;

    localparam int NS = 7;
    localparam int NV = 27;

    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    segment_chaser_if #(.NUM_SEG(NS), .SEQ_LEN(8)) bus ();

    segment_chaser dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        bit         rst;
        logic [1:0] mode;
        bit         dir;
        logic [2:0] spd;
        int         ncyc;
        int         pos;
        int         wraps;
    } vec_t;

    vec_t vt[NV];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   wr    = 0;
    int   duty[NS];
    int   seg_map[8]     = '{0, 1, 6, 4, 3, 2, 6, 5};
    int   fade_start[5]  = '{1500, 2500, 3500, 4500, 5500};
    int   fade_exp[5][NS] = '{'{15, 0, 0, 0, 0, 0, 0},
                              '{ 7,15, 0, 0, 0, 0, 0},
                              '{ 3,15, 0, 0, 0, 0, 0},
                              '{ 1, 7, 0, 0, 0, 0,15},
                              '{ 0, 3, 0, 0, 0, 0,15}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        wr = 0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (bus.wrap === 1'b1) wr++;
        end
    endtask

    task automatic goto_edge(input int e);
        if (e > cyc) run(e - cyc);
    endtask

    // Duty of each segment over one full 16-step PWM period.
    task automatic measure();
        for (int s = 0; s < NS; s++) duty[s] = 0;
        repeat (16) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            for (int s = 0; s < NS; s++) if (bus.seg_out[s] === 1'b1) duty[s]++;
        end
    endtask

    task automatic do_reset(input logic [1:0] m, input bit d, input logic [2:0] sp,
                            input bit tl, input bit inv);
        bus.mode      = m;
        bus.direction = d;
        bus.speed     = sp;
        bus.tail_en   = tl;
        bus.invert    = inv;
        bus.step      = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        vt = '{
            '{1, MODE_LOOP,   1, 0,  255, 0, 0},
            '{0, MODE_LOOP,   1, 0,    1, 1, 0},
            '{0, MODE_LOOP,   1, 0, 1536, 7, 0},
            '{0, MODE_LOOP,   1, 0,  256, 0, 1},
            '{1, MODE_LOOP,   0, 0,  256, 7, 1},
            '{0, MODE_LOOP,   0, 0,  256, 6, 0},
            '{1, MODE_BOUNCE, 1, 0, 1792, 7, 0},
            '{0, MODE_BOUNCE, 1, 0,  256, 6, 1},
            '{0, MODE_BOUNCE, 1, 0, 1536, 0, 0},
            '{0, MODE_BOUNCE, 1, 0,  256, 1, 1},
            '{1, MODE_LOOP,   1, 7, 2047, 0, 0},
            '{0, MODE_LOOP,   1, 7,    1, 1, 0},
            '{0, MODE_LOOP,   1, 7,  600, 1, 0},
            '{0, MODE_LOOP,   1, 0,    1, 1, 0},
            '{0, MODE_LOOP,   1, 0,    1, 2, 0},
            '{0, MODE_LOOP,   1, 0,  256, 3, 0},
            '{1, MODE_LOOP,   1, 0,  100, 0, 0},
            '{0, MODE_HOLD,   1, 0,  400, 0, 0},
            '{0, MODE_LOOP,   1, 0,   11, 0, 0},
            '{0, MODE_LOOP,   1, 0,    1, 1, 0},
            '{1, MODE_LOOP,   1, 0,  254, 0, 0},
            '{0, MODE_HOLD,   1, 0,  256, 0, 0},
            '{0, MODE_LOOP,   1, 0,    2, 1, 0},
            '{1, MODE_LOOP,   1, 0,  512, 2, 0},
            '{0, MODE_BOUNCE, 0, 0,  256, 1, 0},
            '{0, MODE_BOUNCE, 0, 0,  256, 0, 0},
            '{0, MODE_BOUNCE, 0, 0,  256, 1, 1}
        };

        // Reset state
        bus.mode = MODE_LOOP; bus.direction = 1'b1; bus.speed = 3'd0;
        bus.tail_en = 1'b0; bus.invert = 1'b0; bus.step = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset seg_out", bus.seg_out, 0);
        check("reset pos_out", bus.pos_out, 0);
        check("reset wrap", bus.wrap, 0);

        // Position / wrap vectors
        for (int i = 0; i < NV; i++) begin
            if (vt[i].rst) do_reset(vt[i].mode, vt[i].dir, vt[i].spd, 1'b0, 1'b0);
            else begin
                bus.mode      = vt[i].mode;
                bus.direction = vt[i].dir;
                bus.speed     = vt[i].spd;
            end
            run(vt[i].ncyc);
            check($sformatf("vec%0d pos", i), bus.pos_out, vt[i].pos);
            check($sformatf("vec%0d wrap_count", i), wr, vt[i].wraps);
        end

        // Lit segment follows the sequence map, tail off
        do_reset(MODE_LOOP, 1'b1, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            goto_edge(256 * k + 100);
            measure();
            for (int s = 0; s < NS; s++)
                check($sformatf("map pos%0d seg%0d duty", k, s), duty[s],
                      (s == seg_map[k]) ? 15 : 0);
        end

        // Fading tail at speed 7
        do_reset(MODE_LOOP, 1'b1, 3'd7, 1'b1, 1'b0);
        for (int w = 0; w < 5; w++) begin
            goto_edge(fade_start[w] - 1);
            measure();
            for (int s = 0; s < NS; s++)
                check($sformatf("fade w%0d seg%0d duty", w, s), duty[s], fade_exp[w][s]);
        end

        // No tail: only the active segment lights
        do_reset(MODE_LOOP, 1'b1, 3'd7, 1'b0, 1'b0);
        goto_edge(1499);
        measure();
        for (int s = 0; s < NS; s++)
            check($sformatf("notail a seg%0d duty", s), duty[s], (s == 0) ? 15 : 0);
        goto_edge(2499);
        measure();
        for (int s = 0; s < NS; s++)
            check($sformatf("notail b seg%0d duty", s), duty[s], (s == 1) ? 15 : 0);

        // STEP mode
        do_reset(MODE_STEP, 1'b1, 3'd0, 1'b0, 1'b0);
        run(5000);
        check("step idle pos", bus.pos_out, 0);
        check("step idle wrap_count", wr, 0);
        for (int p = 1; p <= 3; p++) begin
            bus.step = 1'b1;
            run(2);
            check($sformatf("step%0d pos before", p), bus.pos_out, p - 1);
            run(1);
            check($sformatf("step%0d pos after", p), bus.pos_out, p);
            run(1);
            bus.step = 1'b0;
            run(4);
        end
        check("step final pos", bus.pos_out, 3);

        // HOLD with invert, then reset mid-period
        do_reset(MODE_LOOP, 1'b1, 3'd0, 1'b0, 1'b0);
        goto_edge(600);
        check("hold pre pos", bus.pos_out, 2);
        bus.mode = MODE_HOLD;
        bus.invert = 1'b1;
        run(1000);
        check("hold pos", bus.pos_out, 2);
        check("hold wrap_count", wr, 0);
        measure();
        for (int s = 0; s < NS; s++)
            check($sformatf("invert seg%0d duty", s), duty[s], (s == 6) ? 1 : 16);
        bus.invert = 1'b0;
        run(1);
        check("invert lat 1 seg0", bus.seg_out[0], 1);
        run(1);
        check("invert lat 2 seg0", bus.seg_out[0], 0);
        bus.invert = 1'b1;
        run(2);
        check("reinvert seg0", bus.seg_out[0], 1);
        reset = 1'b1;
        run(1);
        check("midrun reset seg_out", bus.seg_out, 0);
        check("midrun reset pos_out", bus.pos_out, 0);
        check("midrun reset wrap", bus.wrap, 0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
